apb_ram_subsystem: RTL and testbench

APB_RAM_SUBSYSTEM -- requirements
Module: apb_ram_subsystem

---
 rtl/apb_ram_subsystem.sv | 148 ++++++++++++++
 tb/tb_apb_ram_subsystem.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_ram_subsystem.sv
// APB master front-end driving NUM_BANKS byte-strobed RAM slaves plus a default error slave.
// Requests on the simple transfer/SREADY port become APB SETUP/ACCESS cycles; results return on SDONE.
module apb_ram_subsystem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_BANKS   = 4,
  parameter int BANK_DEPTH  = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    transfer,
  input  logic                    SWRITE,
  input  logic [ADDR_WIDTH-1:0]   SADDR,
  input  logic [DATA_WIDTH-1:0]   SWDATA,
  input  logic [DATA_WIDTH/8-1:0] SSTRB,
  input  logic [2:0]              SPROT,
  output logic                    SREADY,
  output logic                    SDONE,
  output logic [DATA_WIDTH-1:0]   SRDATA,
  output logic                    SERR,
  output logic [NUM_BANKS-1:0]    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int BPW       = DATA_WIDTH / 8;
  localparam int OFF_W     = $clog2(BPW);
  localparam int IDX_W     = $clog2(BANK_DEPTH);
  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int BANK_W    = (NUM_BANKS > 1) ? BANK_BITS : 1;
  localparam int HI_LSB    = OFF_W + IDX_W + BANK_BITS;
  localparam logic [2:0] WAIT_TC = 3'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx_q;
  logic [BANK_W-1:0]       bank_q;
  logic                    dec_err_q;
  logic [2:0]              wait_cnt [NUM_BANKS];
  logic [DATA_WIDTH-1:0]   mem [NUM_BANKS][BANK_DEPTH];

  logic [IDX_W-1:0]        idx_d;
  logic [BANK_W-1:0]       bank_d;
  logic                    dec_err_d;
  logic [NUM_BANKS-1:0]    sel_d;
  logic                    accept;
  logic                    priv_viol;

  // Address decode of the incoming request: word index, bank, overflow and alignment.
  always_comb begin
    idx_d     = IDX_W'(SADDR >> OFF_W);
    bank_d    = '0;
    if (NUM_BANKS > 1) bank_d = BANK_W'(SADDR >> (OFF_W + IDX_W));
    dec_err_d = ((SADDR >> HI_LSB) != '0) || ((SADDR & ADDR_WIDTH'(BPW - 1)) != '0);
    sel_d     = dec_err_d ? '0 : (NUM_BANKS'(1) << bank_d);
  end

  assign priv_viol = !dec_err_q && (bank_q == BANK_W'(NUM_BANKS - 1)) && !PPROT[0];

  always_comb begin
    PREADY = 1'b0;
    if (state == ACCESS) PREADY = dec_err_q || (wait_cnt[bank_q] == WAIT_TC);
  end

  assign PSLVERR = PREADY && (dec_err_q || priv_viol);
  assign SREADY  = (state == IDLE) || ((state == ACCESS) && PREADY);
  assign accept  = transfer && SREADY;

  always_comb begin
    PRDATA = '0;
    if (PENABLE && (PSEL != '0) && !PWRITE && !priv_viol) PRDATA = mem[bank_q][idx_q];
  end

  // RAM is deliberately left out of reset; an asserted PRESET suppresses the write edge.
  always_ff @(posedge PCLK) begin
    if (!PRESET && PREADY && PWRITE && !dec_err_q && !priv_viol) begin
      for (int i = 0; i < BPW; i++) begin
        if (PSTRB[i]) mem[bank_q][idx_q][8*i +: 8] <= PWDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
      SDONE     <= 1'b0;
      SRDATA    <= '0;
      SERR      <= 1'b0;
      idx_q     <= '0;
      bank_q    <= '0;
      dec_err_q <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) wait_cnt[b] <= '0;
    end else begin
      SDONE <= 1'b0;
      case (state)
        IDLE: ;
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
          if (!dec_err_q) wait_cnt[bank_q] <= '0;
        end
        ACCESS: begin
          if (PREADY) begin
            SDONE   <= 1'b1;
            SRDATA  <= PWRITE ? '0 : PRDATA;
            SERR    <= PSLVERR;
            PENABLE <= 1'b0;
            PSEL    <= '0;
            state   <= IDLE;
          end else begin
            wait_cnt[bank_q] <= wait_cnt[bank_q] + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
      // A fresh acceptance (from IDLE or a completing ACCESS) overrides the defaults above.
      if (accept) begin
        state     <= SETUP;
        PADDR     <= SADDR;
        PWRITE    <= SWRITE;
        PWDATA    <= SWDATA;
        PSTRB     <= SWRITE ? SSTRB : '0;
        PPROT     <= SPROT;
        idx_q     <= idx_d;
        bank_q    <= bank_d;
        dec_err_q <= dec_err_d;
        PSEL      <= sel_d;
      end
    end
  end

endmodule

// File: tb/tb_apb_ram_subsystem.sv
// Directed bench for apb_ram_subsystem: a zero-wait instance and a three-wait instance share stimulus,
// with transfer steered to whichever instance is under test.
module tb_apb_ram_subsystem;

  logic        clk = 1'b0;
  logic        rst;
  logic        transfer, swrite;
  logic [31:0] saddr, swdata;
  logic [3:0]  sstrb;
  logic [2:0]  sprot;
  logic        sel;

  logic        sready0, sdone0, serr0, penable0, pwrite0, pready0, pslverr0;
  logic [31:0] srdata0, paddr0, pwdata0, prdata0;
  logic [3:0]  psel0, pstrb0;
  logic [2:0]  pprot0;
  logic        sready1, sdone1, serr1, penable1, pwrite1, pready1, pslverr1;
  logic [31:0] srdata1, paddr1, pwdata1, prdata1;
  logic [3:0]  psel1, pstrb1;
  logic [2:0]  pprot1;

  logic        c_sready, c_sdone, c_serr, c_penable;
  logic [31:0] c_srdata, c_paddr;
  logic [3:0]  c_psel, c_pstrb;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  apb_ram_subsystem #(.WAIT_STATES(0)) u0 (
    .PCLK(clk), .PRESET(rst), .transfer(transfer && !sel), .SWRITE(swrite), .SADDR(saddr),
    .SWDATA(swdata), .SSTRB(sstrb), .SPROT(sprot), .SREADY(sready0), .SDONE(sdone0),
    .SRDATA(srdata0), .SERR(serr0), .PSEL(psel0), .PENABLE(penable0), .PWRITE(pwrite0),
    .PADDR(paddr0), .PWDATA(pwdata0), .PRDATA(prdata0), .PSTRB(pstrb0), .PPROT(pprot0),
    .PREADY(pready0), .PSLVERR(pslverr0));

  apb_ram_subsystem #(.WAIT_STATES(3)) u1 (
    .PCLK(clk), .PRESET(rst), .transfer(transfer && sel), .SWRITE(swrite), .SADDR(saddr),
    .SWDATA(swdata), .SSTRB(sstrb), .SPROT(sprot), .SREADY(sready1), .SDONE(sdone1),
    .SRDATA(srdata1), .SERR(serr1), .PSEL(psel1), .PENABLE(penable1), .PWRITE(pwrite1),
    .PADDR(paddr1), .PWDATA(pwdata1), .PRDATA(prdata1), .PSTRB(pstrb1), .PPROT(pprot1),
    .PREADY(pready1), .PSLVERR(pslverr1));

  assign c_sready  = sel ? sready1  : sready0;
  assign c_sdone   = sel ? sdone1   : sdone0;
  assign c_serr    = sel ? serr1    : serr0;
  assign c_penable = sel ? penable1 : penable0;
  assign c_srdata  = sel ? srdata1  : srdata0;
  assign c_paddr   = sel ? paddr1   : paddr0;
  assign c_psel    = sel ? psel1    : psel0;
  assign c_pstrb   = sel ? pstrb1   : pstrb0;

  typedef struct {
    bit          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
    int          exp_acc;
    bit          exp_sel;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic xfer(input vec_t v, output logic [31:0] rd, output logic er, output int lat,
                      output int acc, output logic sel_any, output logic [3:0] strb_seen);
    int n;
    sel = v.d; swrite = v.wr; saddr = v.addr; swdata = v.data; sstrb = v.strb; sprot = v.prot;
    transfer = 1'b1;
    n = 0;
    while (!c_sready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    transfer = 1'b0;
    lat = 1; acc = 0; sel_any = 1'b0; strb_seen = '0;
    while (!c_sdone && lat < 40) begin
      if (c_penable) begin acc++; strb_seen = c_pstrb; end
      if (c_psel != '0) sel_any = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    rd = c_srdata;
    er = c_serr;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er, sel_any, seen;
    logic [3:0]  strb_seen;
    int          lat, acc;

    rst = 1'b1; transfer = 1'b0; swrite = 1'b0; saddr = '0; swdata = '0; sstrb = '0; sprot = '0;
    sel = 1'b0;

    //          d  wr addr          data          strb  prot  exp_rd        err lat acc sel
    vecs.push_back('{0, 1, 32'h0000_0010, 32'hA5A5_1234, 4'hF, 3'd0, 32'h0,          0, 3, 1, 1});
    vecs.push_back('{0, 0, 32'h0000_0010, 32'h0,         4'hF, 3'd0, 32'hA5A5_1234,  0, 3, 1, 1});
    vecs.push_back('{0, 1, 32'h0000_0020, 32'h1111_1111, 4'hF, 3'd0, 32'h0,          0, 3, 1, 1});
    vecs.push_back('{0, 1, 32'h0000_0020, 32'h0000_00FF, 4'h1, 3'd0, 32'h0,          0, 3, 1, 1});
    vecs.push_back('{0, 0, 32'h0000_0020, 32'h0,         4'h0, 3'd0, 32'h1111_11FF,  0, 3, 1, 1});
    vecs.push_back('{0, 0, 32'h0000_1000, 32'h0,         4'h0, 3'd0, 32'h0,          1, 3, 1, 0});
    vecs.push_back('{0, 0, 32'h0000_0002, 32'h0,         4'h0, 3'd0, 32'h0,          1, 3, 1, 0});
    vecs.push_back('{0, 1, 32'h0000_0C00, 32'hDEAD_BEEF, 4'hF, 3'd0, 32'h0,          1, 3, 1, 1});
    vecs.push_back('{0, 1, 32'h0000_0C00, 32'hCAFE_F00D, 4'hF, 3'd1, 32'h0,          0, 3, 1, 1});
    vecs.push_back('{0, 0, 32'h0000_0C00, 32'h0,         4'h0, 3'd1, 32'hCAFE_F00D,  0, 3, 1, 1});
    vecs.push_back('{0, 0, 32'h0000_0C00, 32'h0,         4'h0, 3'd0, 32'h0,          1, 3, 1, 1});
    vecs.push_back('{0, 1, 32'h0000_0030, 32'h1234_5678, 4'hF, 3'd0, 32'h0,          0, 3, 1, 1});
    vecs.push_back('{0, 1, 32'h0000_0030, 32'hFFFF_FFFF, 4'h0, 3'd0, 32'h0,          0, 3, 1, 1});
    vecs.push_back('{0, 0, 32'h0000_0030, 32'h0,         4'h0, 3'd0, 32'h1234_5678,  0, 3, 1, 1});
    vecs.push_back('{0, 1, 32'h0000_0404, 32'h0102_0304, 4'hF, 3'd0, 32'h0,          0, 3, 1, 1});
    vecs.push_back('{0, 1, 32'h0000_0404, 32'hAABB_CCDD, 4'h6, 3'd0, 32'h0,          0, 3, 1, 1});
    vecs.push_back('{0, 0, 32'h0000_0404, 32'h0,         4'h0, 3'd0, 32'h01BB_CC04,  0, 3, 1, 1});
    vecs.push_back('{0, 1, 32'h0000_0040, 32'h5566_7788, 4'hF, 3'd0, 32'h0,          0, 3, 1, 1});
    vecs.push_back('{1, 1, 32'h0000_0010, 32'h0BAD_F00D, 4'hF, 3'd0, 32'h0,          0, 6, 4, 1});
    vecs.push_back('{1, 1, 32'h0000_0014, 32'h600D_CAFE, 4'hF, 3'd0, 32'h0,          0, 6, 4, 1});

    repeat (3) @(posedge clk);
    #1;
    chk("rst sready", {31'd0, sready0}, 32'd1);
    chk("rst sdone",  {31'd0, sdone0}, 32'd0);
    chk("rst penable", {31'd0, penable0}, 32'd0);
    chk("rst psel",   {28'd0, psel0}, 32'd0);
    chk("rst paddr",  paddr0, 32'd0);
    chk("rst srdata", srdata0, 32'd0);
    chk("rst serr",   {31'd0, serr0}, 32'd0);
    chk("rst pslverr", {31'd0, pslverr0}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      xfer(vecs[i], rd, er, lat, acc, sel_any, strb_seen);
      chk($sformatf("v%0d srdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d serr", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d access_cycles", i), acc, vecs[i].exp_acc);
      chk($sformatf("v%0d psel_any", i), {31'd0, sel_any}, {31'd0, vecs[i].exp_sel});
      chk($sformatf("v%0d pstrb", i), {28'd0, strb_seen}, {28'd0, vecs[i].wr ? vecs[i].strb : 4'h0});
    end

    // Back-to-back reads on the three-wait instance: second SETUP coincides with first SDONE.
    sel = 1'b1; swrite = 1'b0; saddr = 32'h10; sstrb = '0; sprot = '0; transfer = 1'b1;
    chk("b2b idle ready", {31'd0, c_sready}, 32'd1);
    @(posedge clk); #1;
    saddr = 32'h14;
    lat = 1; acc = 0;
    while (!c_sdone && lat < 40) begin
      if (c_penable) acc++;
      @(posedge clk); #1;
      lat++;
    end
    transfer = 1'b0;
    chk("b2b first latency", lat, 6);
    chk("b2b first access", acc, 4);
    chk("b2b first data", c_srdata, 32'h0BAD_F00D);
    chk("b2b setup penable", {31'd0, c_penable}, 32'd0);
    chk("b2b setup psel", {28'd0, c_psel}, 32'h1);
    chk("b2b setup paddr", c_paddr, 32'h14);
    lat = 1; acc = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (c_penable) acc++;
    end while (!c_sdone && lat < 40);
    chk("b2b second latency", lat, 6);
    chk("b2b second access", acc, 4);
    chk("b2b second data", c_srdata, 32'h600D_CAFE);

    // Reset pulse during the ACCESS cycle of an overwrite of 0x40.
    sel = 1'b0; swrite = 1'b1; saddr = 32'h40; swdata = 32'h9999_9999; sstrb = 4'hF; transfer = 1'b1;
    chk("abort ready", {31'd0, c_sready}, 32'd1);
    @(posedge clk); #1;
    transfer = 1'b0;
    @(posedge clk); #1;
    chk("abort in access", {31'd0, c_penable}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort rst sready", {31'd0, c_sready}, 32'd1);
    chk("abort rst penable", {31'd0, c_penable}, 32'd0);
    chk("abort rst psel", {28'd0, c_psel}, 32'd0);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (c_sdone) seen = 1'b1;
    end
    chk("abort no sdone", {31'd0, seen}, 32'd0);
    xfer('{0, 0, 32'h40, 32'h0, 4'h0, 3'd0, 32'h0, 0, 3, 1, 1}, rd, er, lat, acc, sel_any, strb_seen);
    chk("abort read data", rd, 32'h5566_7788);
    chk("abort read latency", lat, 3);
    chk("abort read serr", {31'd0, er}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
